// File: rtl/act_pkg.sv
// Shared activation-unit definitions: per-lane function select encodings.
package act_pkg;

  typedef logic [1:0] act_mode_t;

  localparam act_mode_t ACT_ZERO  = 2'b00;
  localparam act_mode_t ACT_RELU  = 2'b01;
  localparam act_mode_t ACT_LEAKY = 2'b10;
  localparam act_mode_t ACT_CLIP  = 2'b11;

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation: zero, ReLU, leaky ReLU or clipped ReLU.
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic signed [BITWIDTH-1:0] x,
  input  act_mode_t                  mode,
  input  logic        [BITWIDTH-1:0] clip_val,
  output logic signed [BITWIDTH-1:0] y
);

  localparam logic [BITWIDTH-1:0] POS_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};

  logic [BITWIDTH-1:0] clip_eff;

  // A ceiling with the sign bit set is meaningless for a signed lane; pin it to +max
  always_comb begin
    clip_eff = clip_val;
    if (clip_val[BITWIDTH-1]) begin
      clip_eff = POS_MAX;
    end
  end

  // Lane function select; arithmetic shift floors negative values toward -inf
  always_comb begin
    y = '0;
    case (mode)
      ACT_ZERO:  y = '0;
      ACT_RELU:  y = x[BITWIDTH-1] ? '0 : x;
      ACT_LEAKY: y = x[BITWIDTH-1] ? (x >>> LEAK_SHIFT) : x;
      ACT_CLIP: begin
        if (x[BITWIDTH-1]) begin
          y = '0;
        end else if (x > $signed(clip_eff)) begin
          y = $signed(clip_eff);
        end else begin
          y = x;
        end
      end
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// Multi-lane 2-stage valid/ready activation pipeline with saturating zero-lane counter.
module act_pipe
  import act_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned ZCNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*BITWIDTH-1:0]   in_data,
  input  logic [1:0]                   mode,
  input  logic [BITWIDTH-1:0]          clip_val,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*BITWIDTH-1:0]   out_data,
  output logic [ZCNT_W-1:0]            zero_cnt,
  input  logic                         cnt_clr
);

  localparam int unsigned DW    = NUM_CH * BITWIDTH;
  localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W = ZCNT_W + 1;

  logic            s1_valid;
  logic [DW-1:0]   s1_data;
  act_mode_t       s1_mode;
  logic [BITWIDTH-1:0] s1_clip;
  logic            s2_valid;
  logic            s1_adv_c;
  logic            s2_adv_c;
  logic [DW-1:0]   act_data_c;
  logic [PC_W-1:0] zero_lanes_c;
  logic [SUM_W-1:0] zc_sum_c;
  logic            out_fire_c;

  // Stage advance: a stage moves when empty or when the stage after it moves
  assign s2_adv_c   = ~s2_valid | out_ready;
  assign s1_adv_c   = ~s1_valid | s2_adv_c;
  assign in_ready   = s1_adv_c;
  assign out_valid  = s2_valid;
  assign out_fire_c = s2_valid & out_ready;

  // S1: capture the beat with its own mode and ceiling; payload loads only on a real beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= ACT_ZERO;
      s1_clip  <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= act_mode_t'(mode);
        s1_clip <= clip_val;
      end
    end
  end

  // Per-lane activation between S1 and S2
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    act_lane #(
      .BITWIDTH   (BITWIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x        (s1_data[g*BITWIDTH +: BITWIDTH]),
      .mode     (s1_mode),
      .clip_val (s1_clip),
      .y        (act_data_c[g*BITWIDTH +: BITWIDTH])
    );
  end

  // S2: register the activated result; holds while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_adv_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= act_data_c;
      end
    end
  end

  // Count lanes of the presented output that are exactly zero
  always_comb begin
    zero_lanes_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (out_data[i*BITWIDTH +: BITWIDTH] == '0) begin
        zero_lanes_c = zero_lanes_c + PC_W'(1);
      end
    end
  end

  assign zc_sum_c = {1'b0, zero_cnt} + SUM_W'(zero_lanes_c);

  // Saturating statistics counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_cnt <= '0;
    end else if (cnt_clr) begin
      zero_cnt <= '0;
    end else if (out_fire_c) begin
      zero_cnt <= zc_sum_c[ZCNT_W] ? '1 : zc_sum_c[ZCNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// Self-checking bench for act_pipe: directed cases plus random traffic vs a queue model.
module tb_act_pipe;

  localparam int unsigned BW     = 8;
  localparam int unsigned NC     = 4;
  localparam int unsigned LS     = 3;
  localparam int unsigned ZW     = 16;
  localparam int unsigned DW     = NC * BW;
  localparam int          ZC_MAX = (1 << ZW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    mode;
  logic [BW-1:0] clip_val;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [ZW-1:0] zero_cnt;
  logic          cnt_clr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  int            zc_m       = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  act_pipe #(
    .BITWIDTH   (BW),
    .NUM_CH     (NC),
    .LEAK_SHIFT (LS),
    .ZCNT_W     (ZW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .clip_val  (clip_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .zero_cnt  (zero_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference activation written from the lane rules with integer arithmetic
  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input logic [1:0] m,
                                             input logic [BW-1:0] c);
    logic [DW-1:0] r;
    int x, y, cv, div;
    r   = '0;
    div = 1 << LS;
    cv  = (int'(c) >= (1 << (BW - 1))) ? ((1 << (BW - 1)) - 1) : int'(c);
    for (int i = 0; i < NC; i++) begin
      x = int'($signed(d[i*BW +: BW]));
      case (m)
        2'd0:    y = 0;
        2'd1:    y = (x < 0) ? 0 : x;
        2'd2:    y = (x < 0) ? -((-x + div - 1) / div) : x;
        default: y = (x < 0) ? 0 : ((x > cv) ? cv : x);
      endcase
      r[i*BW +: BW] = BW'(y);
    end
    return r;
  endfunction

  function automatic int zeros_in(input logic [DW-1:0] b);
    int n;
    logic [BW-1:0] lane;
    n = 0;
    for (int i = 0; i < NC; i++) begin
      lane = b[i*BW +: BW];
      if (lane == 0) n++;
    end
    return n;
  endfunction

  // One clock: drive, sample mid-cycle, check, advance the model, then take the edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                      input logic [BW-1:0] c, input logic rdy, input logic clr);
    int nzc;
    in_valid  = v;
    in_data   = d;
    mode      = m;
    clip_val  = c;
    out_ready = rdy;
    cnt_clr   = clr;
    #2;
    check("zero_cnt", 32'(zero_cnt), 32'(zc_m));
    check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) || rdy});
    if (prev_stall) begin
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_data", out_data, prev_data);
    end
    if (out_valid) begin
      if (q.size() == 0) check("spurious_valid", {31'b0, out_valid}, 32'd0);
      else               check("out_data", out_data, q[0]);
    end
    nzc = zc_m;
    if (out_valid && rdy && q.size() > 0) begin
      nzc = zc_m + zeros_in(q[0]);
      if (nzc > ZC_MAX) nzc = ZC_MAX;
      void'(q.pop_front());
    end
    if (clr) nzc = 0;
    zc_m       = nzc;
    prev_stall = out_valid && !rdy;
    prev_data  = out_data;
    if (v && in_ready) q.push_back(ref_beat(d, m, c));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 'x, 2'd0, '0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
    check("drain_empty", 32'(q.size()), 32'd0);
    idle(1'b1);
  endtask

  // Single beat with no back-pressure: exact 2-cycle latency and a literal expectation
  task automatic send_one(input string tag, input logic [DW-1:0] d, input logic [1:0] m,
                          input logic [BW-1:0] c, input logic [DW-1:0] exp);
    step(1'b1, d, m, c, 1'b1, 1'b0);
    check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    idle(1'b1);
    check({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
    idle(1'b1);
  endtask

  initial begin
    int zc0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'd0;
    clip_val  = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_zero_cnt", 32'(zero_cnt), 32'd0);
    reset_n = 1'b1;
    idle(1'b1);

    // ReLU with latency and zero-count increment
    zc0 = zc_m;
    send_one("relu", 32'h7F07_00FB, 2'd1, 8'd0, 32'h7F07_0000);
    check("relu_zcnt", 32'(zero_cnt), 32'(zc0 + 2));

    // Leaky ReLU floors negatives
    send_one("leaky", 32'h28F0_FF80, 2'd2, 8'd0, 32'h28FE_FFF0);

    // Clipped ReLU, in-range and sign-bit ceiling
    send_one("clip", 32'hF764_0603, 2'd3, 8'd6, 32'h0006_0603);
    send_one("clip_msb", 32'h0000_007F, 2'd3, 8'h90, 32'h0000_007F);

    // Back-to-back beats, alternating back-pressure, mode changing every beat
    for (int i = 0; i < 16; i++)
      step(1'b1, $urandom, 2'(i % 4), 8'($urandom), 1'(i % 2 == 0), 1'b0);
    drain();

    // Random traffic including X payload while idle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b0, 'x, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      else
        step(1'b1, $urandom, 2'($urandom_range(0, 3)), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
    end
    drain();

    // Saturation: preload to max-1, then overflow attempts
    step(1'b0, 'x, 2'd0, '0, 1'b1, 1'b1);
    for (int i = 0; i < (ZC_MAX - 3) / 4; i++)
      step(1'b1, $urandom, 2'd0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0505_FFFF, 2'd1, '0, 1'b1, 1'b0);
    drain();
    check("preload", 32'(zero_cnt), 32'(ZC_MAX - 1));
    step(1'b1, $urandom, 2'd0, '0, 1'b1, 1'b0);
    drain();
    check("saturate", 32'(zero_cnt), 32'(ZC_MAX));
    step(1'b1, $urandom, 2'd0, '0, 1'b1, 1'b0);
    drain();
    check("saturate_hold", 32'(zero_cnt), 32'(ZC_MAX));

    // Clear takes priority over a same-cycle handshake
    step(1'b1, $urandom, 2'd0, '0, 1'b0, 1'b0);
    idle(1'b0);
    check("clr_valid", {31'b0, out_valid}, 32'd1);
    step(1'b0, 'x, 2'd0, '0, 1'b1, 1'b1);
    check("clr_prio", 32'(zero_cnt), 32'd0);
    drain();

    // Reset with two beats in flight
    step(1'b1, 32'h0, 2'd0, '0, 1'b1, 1'b0);
    drain();
    step(1'b1, $urandom, 2'd1, '0, 1'b0, 1'b0);
    step(1'b1, $urandom, 2'd2, '0, 1'b0, 1'b0);
    check("pre_rst_zcnt", 32'(zero_cnt), 32'(zc_m));
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_zero_cnt", 32'(zero_cnt), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    q.delete();
    zc_m       = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    send_one("post_rst", 32'h8001_7FC0, 2'd1, '0, 32'h0001_7F00);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
